// File: rtl/frame_scan_controller_pkg.sv
// Shared raster constants and scan-state encoding for the pong graphics path.
package pong_gfx_pkg;

    localparam int unsigned H_PIXELS = 240;
    localparam int unsigned V_LINES  = 320;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 9;
    localparam int unsigned RGB_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } scan_state_e;

endpackage

// File: rtl/frame_scan_controller_scan_fifo.sv
// Synchronous FIFO with occupancy count and a registered head word.
module scan_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           rd_en,
    output logic [WIDTH-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push, pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = head_q;

    always_comb begin
        pop      = rd_en && !empty;
        push     = wr_en && (!full || pop);
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
        end
        // Head tracks the next-state read slot so lcd_data comes straight from a flop
        head_d = head_q;
        if (count_d != '0) begin
            head_d = mem_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/frame_scan_controller.sv
// Frame scan sequencer: latches game state, walks the raster through Graphics, streams to LCD.
// Optional checksum output enabled by defining FRAME_SCAN_CHECKSUM_EN.
module frame_scan_controller
    import pong_gfx_pkg::*;
#(
    parameter int unsigned H_PIXELS    = pong_gfx_pkg::H_PIXELS,
    parameter int unsigned V_LINES     = pong_gfx_pkg::V_LINES,
    parameter int unsigned GFX_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [7:0]  ball_x_in,
    input  logic [8:0]  ball_y_in,
    input  logic [7:0]  paddle_1_y_in,
    input  logic [7:0]  paddle_2_y_in,
    output logic [7:0]  ball_x,
    output logic [8:0]  ball_y,
    output logic [7:0]  paddle_1_y,
    output logic [7:0]  paddle_2_y,
    output logic [7:0]  pixel_x,
    output logic [8:0]  pixel_y,
    input  logic [15:0] pixel_rgb,
    output logic [15:0] lcd_data,
    output logic        lcd_valid,
    input  logic        lcd_ready,
    output logic        busy,
`ifdef FRAME_SCAN_CHECKSUM_EN
    output logic        frame_done,
    output logic [15:0] frame_checksum
`else
    output logic        frame_done
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    scan_state_e            state_q, state_d;
    logic [7:0]             ball_x_q, ball_x_d;
    logic [8:0]             ball_y_q, ball_y_d;
    logic [7:0]             paddle_1_y_q, paddle_1_y_d;
    logic [7:0]             paddle_2_y_q, paddle_2_y_d;
    logic [X_W-1:0]         pixel_x_q, pixel_x_d;
    logic [Y_W-1:0]         pixel_y_q, pixel_y_d;
    logic [GFX_LATENCY-1:0] tag_q, tag_d;
    logic [7:0]             in_flight, credit_sum;
    logic [CW-1:0]          fifo_count;
    logic                   fifo_full, fifo_empty;
    logic [RGB_W-1:0]       fifo_head;
    logic                   issue, capture, beat, x_last, y_last;

    always_comb begin
        in_flight = '0;
        for (int unsigned i = 0; i < GFX_LATENCY; i++) begin
            in_flight = in_flight + 8'(tag_q[i]);
        end
        credit_sum = 8'(fifo_count) + in_flight;
        issue      = (state_q == ST_SCAN) && (credit_sum < 8'(FIFO_DEPTH));
        tag_d      = GFX_LATENCY'({tag_q, issue});
        capture    = tag_q[GFX_LATENCY-1];
        beat       = !fifo_empty && lcd_ready;
        x_last     = (pixel_x_q == X_W'(H_PIXELS - 1));
        y_last     = (pixel_y_q == Y_W'(V_LINES - 1));
    end

    always_comb begin
        state_d      = state_q;
        ball_x_d     = ball_x_q;
        ball_y_d     = ball_y_q;
        paddle_1_y_d = paddle_1_y_q;
        paddle_2_y_d = paddle_2_y_q;
        pixel_x_d    = pixel_x_q;
        pixel_y_d    = pixel_y_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                ball_x_d     = ball_x_in;
                ball_y_d     = ball_y_in;
                paddle_1_y_d = paddle_1_y_in;
                paddle_2_y_d = paddle_2_y_in;
                pixel_x_d    = '0;
                pixel_y_d    = '0;
                state_d      = ST_SCAN;
            end
            ST_SCAN: begin
                if (issue) begin
                    if (x_last) begin
                        pixel_x_d = '0;
                        if (y_last) begin
                            pixel_y_d = '0;
                            state_d   = ST_DRAIN;
                        end else begin
                            pixel_y_d = pixel_y_q + 1'b1;
                        end
                    end else begin
                        pixel_x_d = pixel_x_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Leave on the edge that pops the final word so frame_done follows the last beat directly
                if (in_flight == '0 && (fifo_empty || (fifo_count == CW'(1) && beat))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ball_x_q     <= '0;
            ball_y_q     <= '0;
            paddle_1_y_q <= '0;
            paddle_2_y_q <= '0;
            pixel_x_q    <= '0;
            pixel_y_q    <= '0;
            tag_q        <= '0;
        end else begin
            state_q      <= state_d;
            ball_x_q     <= ball_x_d;
            ball_y_q     <= ball_y_d;
            paddle_1_y_q <= paddle_1_y_d;
            paddle_2_y_q <= paddle_2_y_d;
            pixel_x_q    <= pixel_x_d;
            pixel_y_q    <= pixel_y_d;
            tag_q        <= tag_d;
        end
    end

    scan_fifo #(
        .WIDTH(RGB_W),
        .DEPTH(FIFO_DEPTH)
    ) u_scan_fifo (
        .clk     (clock),
        .rst     (reset),
        .wr_en   (capture),
        .wr_data (pixel_rgb),
        .rd_en   (lcd_ready),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // The credit rule must keep every capture landing in a free slot
    capture_overflow_a: assert property (@(posedge clock) disable iff (reset)
        !(capture && fifo_full && !lcd_ready));

    assign ball_x     = ball_x_q;
    assign ball_y     = ball_y_q;
    assign paddle_1_y = paddle_1_y_q;
    assign paddle_2_y = paddle_2_y_q;
    assign pixel_x    = pixel_x_q;
    assign pixel_y    = pixel_y_q;
    assign lcd_data   = fifo_head;
    assign lcd_valid  = !fifo_empty;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);

`ifdef FRAME_SCAN_CHECKSUM_EN
    logic [15:0] crc_q, crc_d;
    logic [15:0] checksum_q, checksum_d;

    always_comb begin
        crc_d = crc_q;
        if (state_q == ST_LATCH) begin
            crc_d = '0;
        end else if (beat) begin
            crc_d = {crc_q[14:0], crc_q[15]} ^ fifo_head;
        end
        checksum_d = (state_q == ST_DONE) ? crc_q : checksum_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            crc_q      <= '0;
            checksum_q <= '0;
        end else begin
            crc_q      <= crc_d;
            checksum_q <= checksum_d;
        end
    end

    assign frame_checksum = checksum_q;
`endif

endmodule
